// File: rtl/temp_reg_sequencer.sv
// temp_reg_sequencer: two-requester command sequencer for an external temp
// register. It arbitrates round-robin between two requesters, issues
// load/increment/decrement strobes, and can step the register to zero.
// Optional build macro SEQ_TIMEOUT_EN: limits RUN_TO_ZERO to MAX_STEPS strobes
// and reports the cutoff on 'timeout'.
module temp_reg_sequencer #(
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       load,
    output logic       increment,
    output logic       decrement,
    output logic [7:0] data_out,
    input  logic       negative,
    input  logic       positive,
    input  logic       zero,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [2:0] done_flags,
    output logic       timeout
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, CHECK, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_DEC, OP_RUN} op_t;

`ifdef SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    state_t     state, state_nx;
    op_t        op_q;
    op_t        op_sel;
    logic       id_q;
    logic       rr_last;
    logic       step_up;
    logic       tmo_q;
    logic       set_tmo;
    logic [7:0] data_q;
    logic [7:0] steps;
    logic       grant0, grant1, accept;

    // Round-robin grant in IDLE; reset masks readies so nothing is accepted.
    always_comb begin
        grant0 = reset_n && (state == IDLE) && req0_valid && (!req1_valid || rr_last);
        grant1 = reset_n && (state == IDLE) && req1_valid && (!req0_valid || !rr_last);
        accept = grant0 || grant1;
        op_sel = op_t'(grant1 ? req1_op : req0_op);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state decode and strobe generation.
    always_comb begin
        state_nx  = state;
        set_tmo   = 1'b0;
        load      = 1'b0;
        increment = 1'b0;
        decrement = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = (op_sel == OP_RUN) ? CHECK : ISSUE;
            end
            ISSUE: begin
                case (op_q)
                    OP_LOAD: load      = 1'b1;
                    OP_INC:  increment = 1'b1;
                    OP_DEC:  decrement = 1'b1;
                    OP_RUN: begin
                        increment = step_up;
                        decrement = !step_up;
                    end
                    default: ;
                endcase
                state_nx = WAIT1;
            end
            WAIT1: state_nx = WAIT2;
            WAIT2: state_nx = (op_q == OP_RUN) ? CHECK : DONE;
            CHECK: begin
                // Anything other than a clean single sign flag terminates.
                if (TIMEOUT_EN && (steps == STEP_LIMIT) && !zero) begin
                    state_nx = DONE;
                    set_tmo  = 1'b1;
                end else if (negative && !positive && !zero) begin
                    state_nx = ISSUE;
                end else if (positive && !negative && !zero) begin
                    state_nx = ISSUE;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, round-robin pointer, step counter and step direction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= OP_LOAD;
            data_q  <= '0;
            id_q    <= 1'b0;
            rr_last <= 1'b1;
            steps   <= '0;
            step_up <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_sel;
                data_q  <= grant1 ? req1_data : req0_data;
                id_q    <= grant1;
                rr_last <= grant1;
                steps   <= '0;
                tmo_q   <= 1'b0;
            end
            if ((state == ISSUE) && (op_q == OP_RUN)) steps <= steps + 8'd1;
            if (state == CHECK) begin
                step_up <= negative;
                if (set_tmo) tmo_q <= 1'b1;
            end
        end
    end

    // Status outputs; completion fields are only driven during DONE.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        data_out   = data_q;
        busy       = (state != IDLE);
        done       = (state == DONE);
        done_id    = done && id_q;
        done_flags = done ? {negative, positive, zero} : 3'b000;
        timeout    = TIMEOUT_EN && done && tmo_q;
    end

endmodule

// File: doc/temp_reg_sequencer.md
TEMP_REG_SEQUENCER -- requirements
Module: temp_reg_sequencer

Interface
REQ-001 Parameter shall be MAX_STEPS, default 255, the maximum number of inc/dec steps one RUN_TO_ZERO may issue (range 1..255).
REQ-002 Port clk shall be input, 1 bit: clock; all state updates on rising edge.
REQ-003 Port reset_n shall be input, 1 bit: reset, synchronous, active-low.
REQ-004 Ports req0_valid, req1_valid shall be input, 1 bit each: requester has a command pending.
REQ-005 Ports req0_op, req1_op shall be input, 2 bits each: 00 LOAD, 01 INC, 10 DEC, 11 RUN_TO_ZERO.
REQ-006 Ports req0_data, req1_data shall be input, 8 bits each: LOAD operand; ignored for other ops.
REQ-007 Ports req0_ready, req1_ready shall be output, 1 bit each: grant; command accepted on valid&&ready.
REQ-008 Ports load, increment, decrement shall be output, 1 bit each: one-cycle strobes to the temp register.
REQ-009 Port data_out shall be output, 8 bits: LOAD operand driven to the temp register.
REQ-010 Ports negative, positive, zero shall be input, 1 bit each: registered sign flags from the temp register.
REQ-011 Port busy shall be output, 1 bit: high in every state except IDLE.
REQ-012 Port done shall be output, 1 bit: one-cycle completion pulse.
REQ-013 Port done_id shall be output, 1 bit: requester index of the completed command; valid with done.
REQ-014 Port done_flags shall be output, 3 bits {negative,positive,zero}: flags sampled at completion; valid with done.
REQ-015 Port timeout shall be output, 1 bit: RUN_TO_ZERO ended by step limit; valid with done.

Function
REQ-016 States shall be IDLE, ISSUE, WAIT1, WAIT2, CHECK, DONE.
REQ-017 In IDLE, readies shall be combinational: at most one high; both valid -> grant goes to the requester not granted last (round-robin); single valid -> that requester.
REQ-018 On acceptance, op, data and id shall be latched, and the round-robin pointer shall update to the granted index.
REQ-019 LOAD/INC/DEC: IDLE -> ISSUE (exactly one strobe high for one cycle; data_out = latched data) -> WAIT1 -> WAIT2 -> DONE; flags are stale until two edges after a strobe.
REQ-020 RUN_TO_ZERO: IDLE -> CHECK; in CHECK: zero -> DONE; negative -> ISSUE with increment; positive -> ISSUE with decrement; then WAIT1 -> WAIT2 -> CHECK.
REQ-021 Each RUN_TO_ZERO strobe shall increment an 8-bit step counter, cleared on acceptance.
REQ-022 DONE shall last one cycle with done=1, done_id, done_flags = input flags sampled that cycle, timeout; then -> IDLE.
REQ-023 Readies shall stay low in all non-IDLE states; new valids wait.
REQ-024 Strobes shall be mutually exclusive and low outside ISSUE; data_out shall hold its last latched value.
REQ-025 Latency: LOAD/INC/DEC done 4 cycles after acceptance; RUN_TO_ZERO from value v with |v| = n steps done 1+4n+1 cycles after acceptance; 2 cycles when already zero.
REQ-026 Flags with no bit set, or with more than one bit set, in CHECK shall be treated as zero (terminate).

Reset
REQ-027 reset_n=0 at a rising edge shall force IDLE, with busy, done, done_id, done_flags, timeout, strobes, readies, data_out and step counter all 0, and round-robin pointer = 1 (req0 wins first tie).
REQ-028 Reset mid-operation shall abandon the command with no done pulse; reset shall override all other inputs in that cycle.

Configuration
REQ-029 With SEQ_TIMEOUT_EN defined, CHECK shall go to DONE with timeout=1 when the step counter equals MAX_STEPS and zero=0.
REQ-030 Without SEQ_TIMEOUT_EN, the step limit shall not exist, RUN_TO_ZERO shall step until zero, and timeout shall be tied 0.

Verification
REQ-031 Reset, then req0 LOAD 0x05 -> load high one cycle with data_out=0x05; done 4 cycles later with done_id=0 and done_flags=010.
REQ-032 req0 and req1 valid together in IDLE twice in succession -> grants req0, then req1, then req0; never both readies high.
REQ-033 Temp=0x03, req1 RUN_TO_ZERO -> 3 decrement strobes 4 cycles apart; done at cycle 14 with done_flags=001 and timeout=0.
REQ-034 Temp=0xFE (negative), RUN_TO_ZERO -> 2 increment strobes; done with done_flags=001.
REQ-035 With SEQ_TIMEOUT_EN and MAX_STEPS=2, temp=0x10, RUN_TO_ZERO -> 2 strobes, then done with timeout=1 and done_flags=010.
REQ-036 Assert reset_n=0 in WAIT1 of an INC -> next cycle IDLE, all outputs 0, no done pulse.
